// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared defaults for the fifo write-side arbiter and for the site that
// instantiates the fifo behind it, so both agree on word width and requester
// count.
//   DEF_N   : default number of requesters
//   DEF_B   : default data word width (must match the fifo's B)
//   DEF_IDW : default requester index width, derived from DEF_N
//   clog2() : ceiling log2, used to derive index widths
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

  // Ceiling log2 with a floor of 1 so a 1-bit index is still legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  localparam int DEF_N   = 4;
  localparam int DEF_B   = 8;
  localparam int DEF_IDW = clog2(DEF_N);

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// ---------------------------------------------------------------------------
// rr_arb_pick
// Purely combinational round-robin search. Starting at rr_ptr_i and wrapping
// modulo N, returns the index of the first asserted request.
//   req_i     [N]   : request vector
//   rr_ptr_i  [IDW] : highest-priority index this cycle (always < N)
//   grant_o   [IDW] : chosen index (0 when no request is present)
//   any_req_o       : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arb_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] rr_ptr_i,
  output logic [IDW-1:0] grant_o,
  output logic           any_req_o
);

  logic found;

  assign any_req_o = |req_i;

  // Walk the N positions starting at the pointer. The index is wrapped by a
  // single subtraction, which is enough because the pointer never reaches N.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    grant_o = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        grant_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of one fifo between N producers using
// round-robin arbitration, with a one-word output stage in front of the fifo.
// The stage only drains while the fifo is not full, so the fifo is never
// written while full.
//   clk            : clock
//   reset          : asynchronous active-high reset
//   en_i           : arbitration enable (stage still drains when low)
//   req_i [N]      : requester i holds a valid word
//   req_data_i     : requester i's word in req_data_i[i*B +: B]
//   ack_o [N]      : one-hot, combinational; word of requester i captured
//   fifo_full_i    : fifo full flag
//   fifo_of_i      : fifo overflow flag
//   fifo_wr_o      : fifo write strobe
//   fifo_w_data_o  : fifo write data (stage contents)
//   busy_o         : stage holds a word
//   last_grant_o   : index of the most recently granted requester
//   err_o          : sticky, set when an overflow was ever observed
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = clog2(N),
  parameter int B   = DEF_B
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  input  logic [N-1:0]   req_i,
  input  logic [N*B-1:0] req_data_i,
  output logic [N-1:0]   ack_o,
  input  logic           fifo_full_i,
  input  logic           fifo_of_i,
  output logic           fifo_wr_o,
  output logic [B-1:0]   fifo_w_data_o,
  output logic           busy_o,
  output logic [IDW-1:0] last_grant_o,
  output logic           err_o
);

  logic           stage_v_q,    stage_v_d;
  logic [B-1:0]   stage_d_q,    stage_d_d;
  logic [IDW-1:0] rr_ptr_q,     rr_ptr_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic           err_q,        err_d;

  logic [IDW-1:0] grant;
  logic           any_req;
  logic           accept;

  rr_arb_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i     (req_i),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (grant),
    .any_req_o (any_req)
  );

  assign fifo_wr_o     = stage_v_q & ~fifo_full_i;
  assign fifo_w_data_o = stage_d_q;
  assign busy_o        = stage_v_q;
  assign last_grant_o  = last_grant_q;
  assign err_o         = err_q;

  // A new word can enter when the stage is empty or is being written to the
  // fifo this same cycle, which sustains one word per cycle.
  assign accept = en_i & any_req & (~stage_v_q | fifo_wr_o);

  always_comb begin
    ack_o = '0;
    if (accept) begin
      ack_o[grant] = 1'b1;
    end
  end

  // Next-state logic. On accept the stage is refilled and the pointer moves
  // just past the winner, wrapping explicitly so it never reaches N even when
  // N is not a power of two. Without accept a drain simply empties the stage.
  always_comb begin
    stage_v_d    = stage_v_q;
    stage_d_d    = stage_d_q;
    rr_ptr_d     = rr_ptr_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | fifo_of_i;
    if (accept) begin
      stage_v_d    = 1'b1;
      stage_d_d    = req_data_i[grant*B +: B];
      last_grant_d = grant;
      rr_ptr_d     = (grant == IDW'(N-1)) ? '0 : grant + 1'b1;
    end else if (fifo_wr_o) begin
      stage_v_d = 1'b0;
    end
  end

  // Asynchronous reset flushes the stage; a word acked but not yet written
  // is intentionally discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_v_q    <= 1'b0;
      stage_d_q    <= '0;
      rr_ptr_q     <= '0;
      last_grant_q <= '0;
      err_q        <= 1'b0;
    end else begin
      stage_v_q    <= stage_v_d;
      stage_d_q    <= stage_d_d;
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (N=4, B=8). Stimulus pushes the
// expected ack index and expected write data into queues; a monitor pops and
// compares them whenever the DUT presents an ack or a fifo write.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int B   = 8;

  logic           clk;
  logic           reset;
  logic           en;
  logic [N-1:0]   req;
  logic [N*B-1:0] reqData;
  logic [N-1:0]   ack;
  logic           fifoFull;
  logic           fifoOf;
  logic           fifoWr;
  logic [B-1:0]   fifoWData;
  logic           busy;
  logic [IDW-1:0] lastGrant;
  logic           err;

  int assertCount = 0;
  int failCount   = 0;

  int          ackQ[$];
  logic [7:0]  dataQ[$];

  fifo_wr_arbiter #(
    .N   (N),
    .IDW (IDW),
    .B   (B)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en),
    .req_i         (req),
    .req_data_i    (reqData),
    .ack_o         (ack),
    .fifo_full_i   (fifoFull),
    .fifo_of_i     (fifoOf),
    .fifo_wr_o     (fifoWr),
    .fifo_w_data_o (fifoWData),
    .busy_o        (busy),
    .last_grant_o  (lastGrant),
    .err_o         (err)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs just after a rising edge, then wait to the falling edge so
  // the caller can sample settled outputs.
  task automatic applyStimulus(input logic enV, input logic [N-1:0] reqV,
                               input logic fullV, input logic ofV);
    en       = enV;
    req      = reqV;
    fifoFull = fullV;
    fifoOf   = ofV;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWord(input int idx, input logic [7:0] data);
    ackQ.push_back(idx);
    dataQ.push_back(data);
  endtask

  task automatic setData(input int idx, input logic [7:0] data);
    reqData[idx*B +: B] = data;
  endtask

  task automatic doReset();
    reset = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever an ack or a fifo write appears.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack != '0) begin
        if (ackQ.size() == 0) begin
          checkOutput("unexpectedAck", 32'(ack), 32'h0);
        end else begin
          checkOutput("ackOneHot", 32'(ack), 32'(1) << ackQ.pop_front());
        end
      end
      if (fifoWr) begin
        if (dataQ.size() == 0) begin
          checkOutput("unexpectedWrite", 32'(fifoWr), 32'h0);
        end else begin
          checkOutput("writeData", 32'(fifoWData), 32'(dataQ.pop_front()));
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    req      = '0;
    reqData  = '0;
    fifoFull = 1'b0;
    fifoOf   = 1'b0;
    #12;
    reset = 1'b0;
    nextCycle();

    $display("[TB] idle after reset");
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      checkOutput("idleWr",   32'(fifoWr), 32'h0);
      checkOutput("idleAck",  32'(ack),    32'h0);
      checkOutput("idleBusy", 32'(busy),   32'h0);
      checkOutput("idleErr",  32'(err),    32'h0);
      nextCycle();
    end

    $display("[TB] single requester");
    setData(0, 8'hA5);
    expectWord(0, 8'hA5);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("singleWr", 32'(fifoWr), 32'h1);
    checkOutput("singleLastGrant", 32'(lastGrant), 32'h0);
    nextCycle();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("singleDrained", 32'(busy), 32'h0);
    nextCycle();

    $display("[TB] all requesting, round robin");
    doReset();
    for (int i = 0; i < N; i++) setData(i, 8'(8'h10 + i));
    for (int k = 0; k < 8; k++) begin
      expectWord(k % N, 8'(8'h10 + (k % N)));
      applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
      if (k > 0) checkOutput("streamWr", 32'(fifoWr), 32'h1);
      nextCycle();
    end
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("streamLastWr", 32'(fifoWr), 32'h1);
    checkOutput("streamLastGrant", 32'(lastGrant), 32'h3);
    nextCycle();

    $display("[TB] fifo full holds stage");
    setData(0, 8'h3C);
    setData(1, 8'h51);
    setData(2, 8'h52);
    expectWord(0, 8'h3C);
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
    nextCycle();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 4'b0110, 1'b1, 1'b0);
      checkOutput("fullWr",   32'(fifoWr), 32'h0);
      checkOutput("fullAck",  32'(ack),    32'h0);
      checkOutput("fullBusy", 32'(busy),   32'h1);
      nextCycle();
    end
    expectWord(1, 8'h51);
    applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0);
    checkOutput("fullReleaseWr",  32'(fifoWr), 32'h1);
    checkOutput("fullReleaseAck", 32'(ack),    32'h2);
    nextCycle();
    expectWord(2, 8'h52);
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    nextCycle();

    $display("[TB] enable gating and pointer wrap");
    setData(3, 8'h63);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
      checkOutput("disabledAck", 32'(ack), 32'h0);
      nextCycle();
    end
    expectWord(3, 8'h63);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    nextCycle();
    setData(0, 8'h70);
    setData(3, 8'h73);
    expectWord(0, 8'h70);
    applyStimulus(1'b1, 4'b1001, 1'b0, 1'b0);
    checkOutput("wrapGrant", 32'(ack), 32'h1);
    nextCycle();
    expectWord(3, 8'h73);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("wrapLastGrant", 32'(lastGrant), 32'h3);
    nextCycle();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    nextCycle();

    $display("[TB] sticky error and async reset");
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    checkOutput("errBeforePulse", 32'(err), 32'h0);
    nextCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      checkOutput("errSticky", 32'(err), 32'h1);
      nextCycle();
    end
    setData(0, 8'h99);
    ackQ.push_back(0);
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    checkOutput("preResetBusy", 32'(busy), 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncResetBusy", 32'(busy),   32'h0);
    checkOutput("asyncResetWr",   32'(fifoWr), 32'h0);
    checkOutput("asyncResetErr",  32'(err),    32'h0);
    checkOutput("asyncResetAck",  32'(ack),    32'h0);
    nextCycle();
    reset    = 1'b0;
    fifoFull = 1'b0;
    nextCycle();

    // Bounded drain of anything still expected
    for (int c = 0; c < 20 && (ackQ.size() != 0 || dataQ.size() != 0); c++) begin
      nextCycle();
    end
    checkOutput("ackQueueEmpty",  32'(ackQ.size()),  32'h0);
    checkOutput("dataQueueEmpty", 32'(dataQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
